// File: rtl/sipo_loader_pkg.sv
// Shared state encodings and sizing helpers for the sipo_loader_4b front end.
package sipo_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOAD   = 2'd2,
    PARITY = 2'd3
  } state_e;

  // Width of a counter able to hold the values 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_loader_4b_shift_reg_sipo.sv
// Serial-to-parallel assembly register; word_c is the value the register takes
// this edge when not cleared, so the top can capture a completed word without delay.
module shift_reg_sipo #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_c
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = sr_q;
    if (MSB_FIRST) begin
      shifted = {sr_q[WIDTH-2:0], bit_in};
    end else begin
      shifted = {bit_in, sr_q[WIDTH-1:1]};
    end
    word_c = shift_en ? shifted : sr_q;
    sr_d   = clear ? '0 : word_c;
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/sipo_loader_4b.sv
// Serial-in/parallel-out loader with one-cycle load strobe and frame abort.
// Define SIPO_PARITY_CHECK_EN to add a trailing even-parity bit per frame.
module sipo_loader_4b
  import sipo_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_sync,
  input  logic                           serial_in,
  input  logic                           serial_valid,
  output logic                           serial_ready,
  input  logic                           frame_abort,
  output logic                           load,
  output logic [WIDTH-1:0]               data_out,
  output logic                           busy,
  output logic [cnt_width(WIDTH)-1:0]    bit_count,
  output logic                           parity_err
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               shift_en;
  logic               sr_clear;
  logic               accept;
  logic [WIDTH-1:0]   word_c;
`ifdef SIPO_PARITY_CHECK_EN
  logic               perr_q, perr_d;
`endif

  shift_reg_sipo #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk        (clk),
    .reset_sync (reset_sync),
    .shift_en   (shift_en),
    .clear      (sr_clear),
    .bit_in     (serial_in),
    .word_c     (word_c)
  );

  // ready_q mirrors (state_q != LOAD), so this is the handshake condition.
  assign accept = serial_valid && ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    shift_en   = 1'b0;
    sr_clear   = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    perr_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // frame_abort is deliberately ignored here
        if (accept) begin
          shift_en = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (frame_abort) begin
          sr_clear = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (accept) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_CHECK_EN
            cnt_d   = CNT_W'(WIDTH);
            state_d = PARITY;
`else
            cnt_d      = '0;
            data_out_d = word_c;
            state_d    = LOAD;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      LOAD: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

`ifdef SIPO_PARITY_CHECK_EN
      PARITY: begin
        if (frame_abort) begin
          sr_clear = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (accept) begin
          cnt_d = '0;
          // word_c holds the stored data word here since shift_en is low
          if ((^word_c ^ serial_in) == 1'b0) begin
            data_out_d = word_c;
            state_d    = LOAD;
          end else begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    load_d  = (state_d == LOAD);
    busy_d  = (state_d == SHIFT) || (state_d == PARITY);
    ready_d = (state_d != LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out_q <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign serial_ready = ready_q;
  assign load         = load_q;
  assign data_out     = data_out_q;
  assign busy         = busy_q;
  assign bit_count    = cnt_q;

endmodule
